// File: rtl/magcmp_pkg.sv
// Shared state codes, verdict encoding and counter-width helper for the
// magnitude-comparator binary searcher.
package magcmp_pkg;

  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StQuery = 2'd1;
  localparam state_t StDone  = 2'd2;

  typedef logic [1:0] verdict_t;
  localparam verdict_t VerdEq = 2'd0;
  localparam verdict_t VerdGt = 2'd1;
  localparam verdict_t VerdLt = 2'd2;

  // Wide enough to count up to width+1 accepted responses.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/magcmp_searcher_if.sv
// Query/response bus between the searcher (master) and a magnitude
// comparator (slave): guess goes out as comparand B, verdict comes back.
interface magcmp_searcher_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] guess;
  logic             guess_valid;
  logic             resp_valid;
  logic             eq;
  logic             gt;
  logic             lt;

  modport master (
    output guess,
    output guess_valid,
    input  resp_valid,
    input  eq,
    input  gt,
    input  lt
  );

  modport slave (
    input  guess,
    input  guess_valid,
    output resp_valid,
    output eq,
    output gt,
    output lt
  );
endinterface

// File: rtl/magcmp_verdict_dec.sv
// Collapses the comparator's eq/gt/lt lines into one verdict (eq > gt > lt).
// ERR_CHECK_EN adds a flag for verdicts that are not exactly one-hot.
module magcmp_verdict_dec
  import magcmp_pkg::*;
(
  input  logic     eq_i,
  input  logic     gt_i,
  input  logic     lt_i,
  output verdict_t verdict_o,
  output logic     invalid_o
);

  // All-zero falls through to lt.
  always_comb begin
    if (eq_i) begin
      verdict_o = VerdEq;
    end else if (gt_i) begin
      verdict_o = VerdGt;
    end else begin
      verdict_o = VerdLt;
    end
  end

`ifdef ERR_CHECK_EN
  // Odd parity excluding the all-ones case means exactly one line is set.
  assign invalid_o = !((eq_i ^ gt_i ^ lt_i) && !(eq_i && gt_i && lt_i));
`else
  logic unused_lt;
  assign unused_lt = lt_i;
  assign invalid_o = 1'b0;
`endif

endmodule

// File: rtl/magcmp_searcher.sv
// Binary-search initiator: drives comparator B with guesses until it hits A.
// Build option ERR_CHECK_EN (in magcmp_verdict_dec) rejects non-one-hot verdicts.
module magcmp_searcher
  import magcmp_pkg::*;
#(
  parameter int unsigned  WIDTH = 4,
  localparam int unsigned CNT_W = cnt_width(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  magcmp_searcher_if.master cmp,
  output logic              done,
  output logic [WIDTH-1:0]  found,
  output logic              error,
  output logic [CNT_W-1:0]  query_cnt
);

  localparam int unsigned    MidW   = WIDTH + 1;
  localparam logic [WIDTH:0] HiInit = {1'b0, {WIDTH{1'b1}}};

  state_t           state_q, state_d;
  logic [WIDTH:0]   lo_q, lo_d, hi_q, hi_d;
  logic [WIDTH-1:0] found_q, found_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH:0]   mid, mid_inc, mid_dec;
  verdict_t         verdict;
  logic             verdict_invalid;

  // Sum carried one bit wider so lo+hi never wraps before the halving.
  assign mid     = MidW'(({1'b0, lo_q} + {1'b0, hi_q}) >> 1);
  assign mid_inc = mid + MidW'(1);
  assign mid_dec = mid - MidW'(1);

  magcmp_verdict_dec u_verdict_dec (
    .eq_i      (cmp.eq),
    .gt_i      (cmp.gt),
    .lt_i      (cmp.lt),
    .verdict_o (verdict),
    .invalid_o (verdict_invalid)
  );

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    found_d = found_q;
    error_d = error_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StQuery;
          lo_d    = '0;
          hi_d    = HiInit;
          found_d = '0;
          error_d = 1'b0;
          cnt_d   = '0;
        end
      end
      StQuery: begin
        if (cmp.resp_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (verdict_invalid) begin
            error_d = 1'b1;
            state_d = StDone;
          end else begin
            case (verdict)
              VerdEq: begin
                found_d = mid[WIDTH-1:0];
                state_d = StDone;
              end
              VerdGt: begin
                lo_d = mid_inc;
                if (mid_inc > hi_q) begin
                  error_d = 1'b1;
                  state_d = StDone;
                end
              end
              default: begin
                if (mid == '0) begin
                  error_d = 1'b1;
                  state_d = StDone;
                end else begin
                  hi_d = mid_dec;
                  if (lo_q > mid_dec) begin
                    error_d = 1'b1;
                    state_d = StDone;
                  end
                end
              end
            endcase
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lo_q    <= '0;
      hi_q    <= '0;
      found_q <= '0;
      error_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      found_q <= found_d;
      error_q <= error_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cmp.guess       = mid[WIDTH-1:0];
  assign cmp.guess_valid = (state_q == StQuery);
  assign done            = (state_q == StDone);
  assign found           = found_q;
  assign error           = error_q;
  assign query_cnt       = cnt_q;

endmodule

// File: tb/tb_magcmp_searcher.sv
// Scoreboard bench for magcmp_searcher: searches against an integer binary-search
// model, lying responders, an exhaustive WIDTH=2 instance and a mid-search reset.
module tb_magcmp_searcher;
  import magcmp_pkg::*;

  localparam int unsigned W   = 4;
  localparam int unsigned CW  = cnt_width(W);
  localparam int unsigned W2  = 2;
  localparam int unsigned CW2 = cnt_width(W2);
  localparam int          Bound = 250;

  typedef struct {
    int found;
    bit err;
    int cnt;
    bit tied;
  } res_t;

  logic clk = 1'b0;
  logic rst_n, start, start2;
  logic done, error, done2, error2;
  logic [W-1:0]   found;
  logic [CW-1:0]  query_cnt;
  logic [W2-1:0]  found2;
  logic [CW2-1:0] query_cnt2;

  // Responder controls; mode 0 honest, 1 always lt, 2 eq+gt together, 3 always gt.
  int secret4 = 0, mode4 = 0, secret2 = 0;
  bit tie_valid = 1'b1, rv_rand = 1'b0;

  int n_vec = 0, n_bad = 0;
  int cyc = 0;
  bit rst_at_edge = 1'b0, st_acc = 1'b0, st2_acc = 1'b0;
  int   exp_guess_q[$];
  res_t exp_res_q[$];
  res_t exp2_res_q[$];

  magcmp_searcher_if #(.WIDTH(W))  cif  ();
  magcmp_searcher_if #(.WIDTH(W2)) cif2 ();

  magcmp_searcher #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cmp       (cif),
    .done      (done),
    .found     (found),
    .error     (error),
    .query_cnt (query_cnt)
  );

  magcmp_searcher #(.WIDTH(W2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start2),
    .cmp       (cif2),
    .done      (done2),
    .found     (found2),
    .error     (error2),
    .query_cnt (query_cnt2)
  );

  always #5 clk = ~clk;

  always_comb begin
    cif.eq = 1'b0;
    cif.gt = 1'b0;
    cif.lt = 1'b0;
    case (mode4)
      1: cif.lt = 1'b1;
      2: begin
        cif.eq = 1'b1;
        cif.gt = 1'b1;
      end
      3: cif.gt = 1'b1;
      default: begin
        cif.eq = (secret4 == int'(cif.guess));
        cif.gt = (secret4 >  int'(cif.guess));
        cif.lt = (secret4 <  int'(cif.guess));
      end
    endcase
  end
  // Untied mode also asserts resp_valid outside QUERY, which must be ignored.
  assign cif.resp_valid = tie_valid ? cif.guess_valid : rv_rand;

  always_comb begin
    cif2.eq = (secret2 == int'(cif2.guess));
    cif2.gt = (secret2 >  int'(cif2.guess));
    cif2.lt = (secret2 <  int'(cif2.guess));
  end
  assign cif2.resp_valid = cif2.guess_valid;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rv_rand     <= ($urandom_range(0, 2) != 0);
    rst_at_edge <= !rst_n;
    st_acc      <= rst_n && start && !cif.guess_valid;
    st2_acc     <= rst_n && start2 && !cif2.guess_valid;
  end

  // Plain binary search over integers; v: 0 eq, 1 gt, 2 lt, 3 malformed.
  task automatic ref_search(input int w, input int secret, input int mode, input bit push,
                            output res_t r);
    int lo, hi, mid, v;
    bit fin;
    lo = 0;
    hi = (1 << w) - 1;
    fin = 1'b0;
    r.found = 0;
    r.err = 1'b0;
    r.cnt = 0;
    r.tied = 1'b0;
    while (!fin) begin
      mid = (lo + hi) / 2;
      if (push) exp_guess_q.push_back(mid);
      r.cnt = r.cnt + 1;
      case (mode)
        1: v = 2;
        2: v = 3;
        3: v = 1;
        default: v = (secret == mid) ? 0 : ((secret > mid) ? 1 : 2);
      endcase
`ifndef ERR_CHECK_EN
      if (v == 3) v = 0;
`endif
      fin = 1'b1;
      if (v == 3) r.err = 1'b1;
      else if (v == 0) r.found = mid;
      else if (v == 1 && mid + 1 <= hi) begin
        lo = mid + 1;
        fin = 1'b0;
      end else if (v == 2 && mid > 0 && lo <= mid - 1) begin
        hi = mid - 1;
        fin = 1'b0;
      end else r.err = 1'b1;
    end
  endtask

  function automatic void chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void fail_evt(input string name, input string what);
    n_vec++;
    n_bad++;
    $display("FAIL %s: %s", name, what);
  endfunction

  initial begin : monitor
    bit   done_prev = 1'b0, done2_prev = 1'b0;
    int   start_cyc = 0, start2_cyc = 0, wd = 0, wd2 = 0;
    res_t r;
    forever begin
      @(negedge clk);
      if (rst_at_edge) begin
        chk("rst_guess", int'(cif.guess), 0);
        chk("rst_guess_valid", int'(cif.guess_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_found", int'(found), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_query_cnt", int'(query_cnt), 0);
        chk("rst_done2", int'(done2), 0);
        chk("rst_guess_valid2", int'(cif2.guess_valid), 0);
        exp_guess_q.delete();
        exp_res_q.delete();
        exp2_res_q.delete();
      end
      if (st_acc) begin
        start_cyc = cyc;
        chk("start_guess_valid", int'(cif.guess_valid), 1);
        chk("start_query_cnt", int'(query_cnt), 0);
        chk("start_error", int'(error), 0);
      end
      if (st2_acc) start2_cyc = cyc;
      if (cif.guess_valid && done) fail_evt("exclusive", "guess_valid and done both high");
      if (cif.guess_valid && cif.resp_valid) begin
        if (exp_guess_q.size() == 0)
          fail_evt("guess", $sformatf("got %0d, expected no query", cif.guess));
        else chk("guess", int'(cif.guess), exp_guess_q.pop_front());
      end
      if (done && !done_prev) begin
        if (exp_res_q.size() == 0) fail_evt("done", "got done=1, expected no search");
        else begin
          r = exp_res_q.pop_front();
          wd = 0;
          chk("error", int'(error), int'(r.err));
          if (!r.err) chk("found", int'(found), r.found);
          chk("query_cnt", int'(query_cnt), r.cnt);
          chk("cnt_bound", int'(int'(query_cnt) <= W + 1), 1);
          chk("guesses_consumed", exp_guess_q.size(), 0);
          if (r.tied) chk("done_latency", cyc - start_cyc, r.cnt);
        end
      end else if (exp_res_q.size() != 0) wd++;
      else wd = 0;
      if (wd > Bound) begin
        fail_evt("watchdog", $sformatf("got no done after %0d cycles, expected done", wd));
        exp_guess_q.delete();
        exp_res_q.delete();
        wd = 0;
      end
      done_prev = done;

      if (done2 && !done2_prev) begin
        if (exp2_res_q.size() == 0) fail_evt("done2", "got done=1, expected no search");
        else begin
          r = exp2_res_q.pop_front();
          wd2 = 0;
          chk("error2", int'(error2), int'(r.err));
          chk("found2", int'(found2), r.found);
          chk("query_cnt2", int'(query_cnt2), r.cnt);
          chk("cnt_bound2", int'(int'(query_cnt2) <= W2 + 1), 1);
          chk("done_latency2", cyc - start2_cyc, r.cnt);
        end
      end else if (exp2_res_q.size() != 0) wd2++;
      else wd2 = 0;
      if (wd2 > Bound) begin
        fail_evt("watchdog2", $sformatf("got no done after %0d cycles, expected done", wd2));
        exp2_res_q.delete();
        wd2 = 0;
      end
      done2_prev = done2;
    end
  end

  task automatic run4(input int secret, input int mode, input bit tie);
    res_t r;
    @(negedge clk);
    ref_search(W, secret, mode, 1'b1, r);
    r.tied = tie;
    secret4 = secret;
    mode4 = mode;
    tie_valid = tie;
    exp_res_q.push_back(r);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Stray starts while querying must be ignored.
    for (int i = 0; i < Bound + 50 && !done; i++) begin
      start = !tie && cif.guess_valid && ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic run2(input int secret);
    res_t r;
    @(negedge clk);
    ref_search(W2, secret, 0, 1'b0, r);
    r.tied = 1'b1;
    secret2 = secret;
    exp2_res_q.push_back(r);
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < Bound + 50 && !done2; i++) @(negedge clk);
  endtask

  initial begin : driver
    res_t r;
    int   m;
    rst_n = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run4(11, 0, 1'b1);
    run4(0, 0, 1'b1);
    run4(15, 0, 1'b1);
    run4(5, 1, 1'b1);
    run4(9, 3, 1'b1);
    run4(6, 2, 1'b1);

    // Abort a search for 15 in its third query cycle.
    @(negedge clk);
    ref_search(W, 15, 0, 1'b1, r);
    r.tied = 1'b1;
    secret4 = 15;
    mode4 = 0;
    tie_valid = 1'b1;
    exp_res_q.push_back(r);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run4(15, 0, 1'b1);

    for (int s = 0; s < 4; s++) run2(s);

    repeat (60) begin
      m = int'($urandom_range(0, 9));
      run4(int'($urandom_range(0, 15)), (m < 7) ? 0 : m - 6, 1'(int'($urandom_range(0, 1))));
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
